// File: rtl/out_pack_quant.sv
// out_pack_quant
//   Requantizes signed accumulator lanes to int8 (arithmetic right shift,
//   then saturation to -128..127) and packs consecutive beats LSB-first
//   into WIDTH-bit output words. One dat_vld pulse is produced per full
//   word. The final partial word of a frame is zero-filled and emitted
//   together with frame_done.
//
// Build option:
//   OUT_PACK_ROUND_EN  defined   -> round half up before the shift
//                      undefined -> truncate (shift toward -inf)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          frame start pulse (honoured only in IDLE)
//   frame_beats    input beats in the frame (sampled on start)
//   shift          right-shift amount (sampled on start)
//   busy           high in RUN and DONE
//   in_rdy         high only in RUN
//   in_vld/in_dat  input beat; lane i at [i*ACC_W +: ACC_W]
//   dat_vld/dat    registered output word, single-cycle valid pulse
//   word_num       ceil(frame_beats/PACK)-1, registered on start
//   frame_done     single-cycle pulse at frame end
module out_pack_quant #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned LANES = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned PACK  = WIDTH / (LANES * 8),
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         frame_beats,
    input  logic [3:0]               shift,
    output logic                     busy,
    output logic                     in_rdy,
    input  logic                     in_vld,
    input  logic [LANES*ACC_W-1:0]   in_dat,
    output logic                     dat_vld,
    output logic [WIDTH-1:0]         dat,
    output logic [CNT_W-1:0]         word_num,
    output logic                     frame_done
);

    localparam int unsigned BEAT_W  = LANES * 8;
    localparam int unsigned SLOT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PACK_SH = $clog2(PACK);

    localparam logic signed [ACC_W:0] SAT_MAX = 127;
    localparam logic signed [ACC_W:0] SAT_MIN = -128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_beats_left;
    logic [3:0]          r_shift;
    logic [SLOT_W-1:0]   r_slot;
    logic [WIDTH-1:0]    r_pack;
    logic [WIDTH-1:0]    r_dat;
    logic                r_dat_vld;
    logic [CNT_W-1:0]    r_word_num;

    logic                w_start_frame;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_word_end;
    logic [BEAT_W-1:0]   w_q_beat;
    logic [WIDTH-1:0]    w_pack_nxt;
    logic [CNT_W-1:0]    w_word_num;

    // Shift (optionally rounded) in ACC_W+1 bits so the rounding add cannot
    // overflow, then clamp to int8.
    function automatic logic [7:0] quant(input logic [ACC_W-1:0] acc,
                                         input logic [3:0]       sh);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] shd;
        ext = $signed({acc[ACC_W-1], acc});
`ifdef OUT_PACK_ROUND_EN
        if (sh != 4'd0) begin
            ext = ext + $signed((ACC_W+1)'(1) << (sh - 4'd1));
        end
`endif
        shd = ext >>> sh;
        if (shd > SAT_MAX) begin
            quant = 8'h7f;
        end else if (shd < SAT_MIN) begin
            quant = 8'h80;
        end else begin
            quant = shd[7:0];
        end
    endfunction

    assign w_start_frame = (r_state == S_IDLE) && start && (frame_beats != '0);
    assign w_accept      = in_vld && (r_state == S_RUN);
    assign w_last_beat   = (r_beats_left == CNT_W'(1));
    assign w_word_end    = (r_slot == SLOT_W'(PACK - 1)) || w_last_beat;

    // ceil(n/PACK)-1 == (n-1)/PACK for n > 0; PACK is a power of two.
    assign w_word_num    = (frame_beats - CNT_W'(1)) >> PACK_SH;

    always_comb begin
        w_q_beat = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_q_beat[l*8 +: 8] = quant(in_dat[l*ACC_W +: ACC_W], r_shift);
        end
    end

    // Slot 0 starts from an all-zero word, so any slots left unfilled at
    // frame end are already zero when the word is emitted.
    always_comb begin
        w_pack_nxt = (r_slot == '0) ? '0 : r_pack;
        for (int unsigned p = 0; p < PACK; p++) begin
            if (r_slot == SLOT_W'(p)) begin
                w_pack_nxt[p*BEAT_W +: BEAT_W] = w_q_beat;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (frame_beats != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy       = 1'b0;
        in_rdy     = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            S_RUN: begin
                busy   = 1'b1;
                in_rdy = 1'b1;
            end
            S_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: counters, pack register, output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats_left <= '0;
            r_shift      <= '0;
            r_slot       <= '0;
            r_pack       <= '0;
            r_dat        <= '0;
            r_dat_vld    <= 1'b0;
            r_word_num   <= '0;
        end else begin
            r_dat_vld <= 1'b0;
            if (w_start_frame) begin
                r_beats_left <= frame_beats;
                r_shift      <= shift;
                r_word_num   <= w_word_num;
                r_slot       <= '0;
            end else if (w_accept) begin
                r_pack       <= w_pack_nxt;
                r_beats_left <= r_beats_left - CNT_W'(1);
                if (w_word_end) begin
                    r_dat     <= w_pack_nxt;
                    r_dat_vld <= 1'b1;
                    r_slot    <= '0;
                end else begin
                    r_slot <= r_slot + SLOT_W'(1);
                end
            end
        end
    end

    assign dat_vld  = r_dat_vld;
    assign dat      = r_dat;
    assign word_num = r_word_num;

endmodule

// File: tb/tb_out_pack_quant.sv
// Randomized scoreboard bench for out_pack_quant. The driver computes each
// expected output word from a plain-arithmetic int8 requantization model and
// queues it with the cycle it should appear; a negedge monitor pops and
// compares whenever dat_vld or frame_done is seen.
module tb_out_pack_quant;

    localparam int WIDTH = 256;
    localparam int LANES = 8;
    localparam int ACC_W = 16;
    localparam int PACK  = 4;
    localparam int CNT_W = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [CNT_W-1:0]       frame_beats;
    logic [3:0]             shift;
    logic                   busy;
    logic                   in_rdy;
    logic                   in_vld;
    logic [LANES*ACC_W-1:0] in_dat;
    logic                   dat_vld;
    logic [WIDTH-1:0]       dat;
    logic [CNT_W-1:0]       word_num;
    logic                   frame_done;

    out_pack_quant #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .ACC_W (ACC_W),
        .PACK  (PACK),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frame_beats (frame_beats),
        .shift       (shift),
        .busy        (busy),
        .in_rdy      (in_rdy),
        .in_vld      (in_vld),
        .in_dat      (in_dat),
        .dat_vld     (dat_vld),
        .dat         (dat),
        .word_num    (word_num),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit               empty;
        bit               last;
        logic [WIDTH-1:0] word;
        int               cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;

    int cur_lanes[$];
    int cur_sh;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // int8 requantization from first principles: floor(v / 2^sh), optionally
    // floor((v + 2^(sh-1)) / 2^sh), then clamp.
    function automatic logic [7:0] qmodel(input int v_in, input int sh);
        int d;
        int v;
        int q;
        d = 1 << sh;
        v = v_in;
`ifdef OUT_PACK_ROUND_EN
        if (sh > 0) v = v + d / 2;
`endif
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    // Byte n of the word is lane (n % LANES) of beat (n / LANES) of this word.
    function automatic logic [WIDTH-1:0] build_word();
        logic [WIDTH-1:0] w;
        w = '0;
        foreach (cur_lanes[i]) w[i*8 +: 8] = qmodel(cur_lanes[i], cur_sh);
        return w;
    endfunction

    function automatic int gen_lane(input int mode, input int lane);
        int v;
        case (mode)
            1: v = 5;
            2: begin
                case (lane % 4)
                    0: v = 1000;
                    1: v = -1000;
                    2: v = -6;
                    default: v = 6;
                endcase
            end
            3: v = int'($urandom_range(0, 1023)) - 512;
            default: v = int'($urandom_range(0, 65535)) - 32768;
        endcase
        return v;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n && (dat_vld || frame_done)) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got dat_vld=%0b frame_done=%0b expected none at cycle %0d",
                         dat_vld, frame_done, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_cycle", cyc, mon_e.cyc);
                chk("frame_done", frame_done, mon_e.last);
                if (mon_e.empty) begin
                    chk("empty_no_dat_vld", dat_vld, 1'b0);
                end else begin
                    chk("dat_vld", dat_vld, 1'b1);
                    chk("dat", dat, mon_e.word);
                end
            end
        end
    end

    task automatic idle_cycle();
        in_vld = 1'b0;
        for (int l = 0; l < LANES; l++) in_dat[l*ACC_W +: ACC_W] = ACC_W'($urandom);
        @(posedge clk);
        #1;
    endtask

    // gap: 0 none, 1 one idle cycle between beats, 2 random 0..2 idle cycles
    // abort_at: beat index at which rst_n is pulsed (-1 for none)
    task automatic run_frame(input int fb, input int sh, input int mode,
                             input int gap, input bit start_in_run,
                             input int abort_at);
        int ts;
        int kb;
        int waitc;
        int exp_wn;
        exp_t e;
        @(posedge clk);
        #1;
        start       = 1'b1;
        frame_beats = CNT_W'(fb);
        shift       = 4'(sh);
        ts          = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cur_sh = sh;
        cur_lanes.delete();
        if (fb == 0) begin
            e.empty = 1'b1; e.last = 1'b1; e.word = '0; e.cyc = ts + 1;
            sbq.push_back(e);
            chk("empty_busy", busy, 1'b1);
            chk("empty_rdy", in_rdy, 1'b0);
            @(posedge clk);
            #1;
            chk("empty_rdy_after", in_rdy, 1'b0);
            chk("empty_idle", busy, 1'b0);
            return;
        end
        exp_wn = (fb + PACK - 1) / PACK - 1;
        chk("start_busy", busy, 1'b1);
        chk("start_rdy", in_rdy, 1'b1);
        chk("word_num", word_num, CNT_W'(exp_wn));
        for (int b = 0; b < fb; b++) begin
            if (b == abort_at) begin
                in_vld = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_rdy", in_rdy, 1'b0);
                chk("rst_dat_vld", dat_vld, 1'b0);
                chk("rst_dat", dat, '0);
                chk("rst_word_num", word_num, '0);
                chk("rst_frame_done", frame_done, 1'b0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                cur_lanes.delete();
                return;
            end
            if (gap == 1 && b > 0) begin
                if (start_in_run) begin
                    start       = 1'b1;
                    frame_beats = CNT_W'(3);
                end
                idle_cycle();
                start       = 1'b0;
                frame_beats = CNT_W'(fb);
            end else if (gap == 2) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
            end
            for (int l = 0; l < LANES; l++) begin
                int v;
                v = gen_lane(mode, l);
                cur_lanes.push_back(v);
                in_dat[l*ACC_W +: ACC_W] = ACC_W'(v);
            end
            in_vld = 1'b1;
            waitc  = 0;
            while (!in_rdy && waitc < 50) begin
                @(posedge clk);
                #1;
                waitc++;
            end
            if (!in_rdy) begin
                tests++;
                fails++;
                $display("FAIL in_rdy_timeout: got in_rdy=0 expected 1 at beat %0d", b);
                in_vld = 1'b0;
                return;
            end
            kb = cyc;
            @(posedge clk);
            #1;
            if ((b % PACK) == PACK - 1 || b == fb - 1) begin
                e.empty = 1'b0;
                e.last  = (b == fb - 1);
                e.word  = build_word();
                e.cyc   = kb + 1;
                sbq.push_back(e);
                cur_lanes.delete();
            end
        end
        chk("rdy_after_last", in_rdy, 1'b0);
        chk("word_num_held", word_num, CNT_W'(exp_wn));
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        int waitc;
        rst_n       = 1'b0;
        start       = 1'b0;
        frame_beats = '0;
        shift       = '0;
        in_vld      = 1'b0;
        in_dat      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_rdy", in_rdy, 1'b0);
        chk("reset_dat_vld", dat_vld, 1'b0);
        chk("reset_dat", dat, '0);
        chk("reset_word_num", word_num, '0);
        chk("reset_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;

        run_frame(8, 0, 1, 0, 1'b0, -1);   // exact words, all 0x05
        run_frame(5, 0, 0, 0, 1'b0, -1);   // partial final word
        run_frame(4, 2, 2, 0, 1'b0, -1);   // saturation / rounding pattern
        run_frame(4, 1, 3, 1, 1'b1, -1);   // gapped input, start during RUN
        run_frame(0, 0, 0, 0, 1'b0, -1);   // empty frame
        run_frame(8, 0, 0, 0, 1'b0, 2);    // reset after two beats
        run_frame(4, 0, 3, 0, 1'b0, -1);   // next frame packs from slot 0

        for (int n = 0; n < 30; n++) begin
            run_frame(int'($urandom_range(0, 13)), int'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 0) ? 0 : 3,
                      int'($urandom_range(0, 2)), 1'b0, -1);
        end

        waitc = 0;
        while (sbq.size() != 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        #1;
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d outputs pending expected 0", sbq.size());
        end
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
